rv64_alu: RTL and testbench
===========================

# rv64_alu

Single-cycle-registered RV64I integer ALU for the execute stage. It decodes an `operation_specification` (OP / OP-IMM instructions), selects the second operand from `rhs` or the sign-extended immediate, and computes the result. The result is registered with a valid flag derived from operand readiness and decode legality. A behavioural model with an identical port list is compared against it cycle by cycle.

## Interface
- `DATA_WIDTH`, default 64: operand and result width; the only supported value is 64.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous, active-low.
- `lhs`, input, DATA_WIDTH: rs1 operand value.
- `rhs`, input, DATA_WIDTH: rs2 operand value; ignored for I-format.
- `lhs_valid`, input, 1: `lhs` holds a ready value.
- `rhs_valid`, input, 1: `rhs` holds a ready value.
- `op_spec`, input, `operation_specification`: fields are `opcode[6:0]`, `rs1[4:0]`, `funct3[2:0]`, `rs2[4:0]`, `rd[4:0]`, `funct7[6:0]`, `imm[11:0]` and `encoding` (`R_FORMAT` / `I_FORMAT`).
- `result`, output, DATA_WIDTH: computed value.
- `result_valid`, output, 1: `result` is meaningful.

## Operation
- Operand B:
  - R_FORMAT: B = `rhs`.
  - I_FORMAT: B = `imm` sign-extended to 64 bits.
- Legal combinations:
  - opcode 7'b0110011 only with R_FORMAT.
  - opcode 7'b0010011 only with I_FORMAT.
  - Any other opcode/encoding pairing is illegal.
- funct3 decode:
  - 000 is ADD. It is SUB only for R_FORMAT with funct7 = 7'h20; ADDI never subtracts.
  - 001 is SLL.
  - 010 is SLT (signed compare), result 64'd0 or 64'd1.
  - 011 is SLTU (unsigned compare), result 64'd0 or 64'd1.
  - 100 is XOR.
  - 101 is SRL, or SRA when arithmetic is selected.
  - 110 is OR.
  - 111 is AND.
- Shift amount:
  - R_FORMAT: `rhs[5:0]`.
  - I_FORMAT: `imm[5:0]`.
- Shift type:
  - R_FORMAT: funct7 = 7'h20 selects arithmetic.
  - I_FORMAT: `imm[11:6]` = 6'b010000 selects arithmetic; 6'b000000 selects logical.
- R_FORMAT funct7 legality:
  - funct7 must be 7'h00 or 7'h20.
  - 7'h20 is legal only with funct3 000 or 101.
- I_FORMAT legality:
  - funct7 is ignored.
  - For funct3 001 and 101, `imm[11:6]` must be 000000 (SLLI/SRLI) or 010000 (SRAI only).
- Valid rules:
  - operands_ready = `lhs_valid` && (I_FORMAT || `rhs_valid`).
  - `result_valid` = operands_ready && legal.
- `rs1`, `rs2` and `rd` are not used.
- Arithmetic wraps modulo 2^64; there are no flags and no exceptions.

## Timing
- Every posedge `clk`:
  - `result` ← f(current inputs).
  - `result_valid` ← valid rule applied to current inputs.
- Latency is exactly 1 cycle, throughput is one operation per cycle, and there is no backpressure.
- `rst` low at a posedge: `result` = 64'h0 and `result_valid` = 0 on the next cycle. Reset overrides any in-flight input, including reset asserted mid-stream.
- When `result_valid` = 0, `result` is don't-care for comparison. The implementation still registers the computed value.

## Configuration
- Macro `RV64_ALU_ILLEGAL_CHECK_EN`.
- Defined: illegal encodings force `result_valid` = 0, per the legality rules above.
- Undefined:
  - No legality check; `result_valid` = operands_ready.
  - Unrecognised funct7 / `imm[11:6]` values decode as funct7 = 0 (ADD / SLL / SRL).
  - An opcode/encoding mismatch follows `encoding`.
- The behavioural model must honour the same macro.

## Structure
- Package `rv64_alu_pkg` holds:
  - `operation_specification` struct.
  - `encoding` enum {R_FORMAT, I_FORMAT}.
  - opcode constants OP = 7'b0110011 and OP_IMM = 7'b0010011.
  - funct3 constants.
  - funct7 constants 7'h00 and 7'h20.
- One natural sub-module, `rv64_alu_shifter`: combinational 64-bit SLL/SRL/SRA taking a 6-bit amount and an arithmetic flag.
- Decode, operand mux and output register stay in the top level.

## Test plan
- R ADD, then SUB:
  - lhs = 5, rhs = 3, funct3 = 000, funct7 = 0, both valid → next cycle `result` = 8, `result_valid` = 1.
  - Same operands with funct7 = 7'h20 → `result` = 2.
- I SRAI vs SRLI:
  - lhs = 64'h8000_0000_0000_0000, imm = 12'h404 (arithmetic, shamt 4) → `result` = 64'hF800_0000_0000_0000.
  - imm = 12'h004 → `result` = 64'h0800_0000_0000_0000.
- SLT/SLTU sign handling:
  - lhs = 64'hFFFF_FFFF_FFFF_FFFF, rhs = 1 → SLT result = 1.
  - Same operands → SLTU result = 0.
- Valid gating:
  - R_FORMAT with `rhs_valid` = 0 → `result_valid` = 0.
  - I_FORMAT ADDI imm = 12'hFFF with lhs = 1, `rhs_valid` = 0 → `result` = 0, `result_valid` = 1.
- Illegal decode (macro defined):
  - opcode 0010011 with R_FORMAT → `result_valid` = 0.
  - R XOR with funct7 = 7'h20 → `result_valid` = 0.
- Reset:
  - `rst` = 0 while a valid ADD is presented → next cycle `result` = 0, `result_valid` = 0.
  - Release `rst` → normal operation on the following cycle.

Source files
------------

// File: rtl/rv64_alu_pkg.sv
// rv64_alu_pkg: shared types and decode constants for the RV64I execute-stage ALU.
// The optional legality check is controlled by RV64_ALU_ILLEGAL_CHECK_EN (see rv64_alu.sv).
package rv64_alu_pkg;

  localparam int XLEN = 64;

  typedef enum logic {
    R_FORMAT = 1'b0,
    I_FORMAT = 1'b1
  } encoding_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  funct7;
    logic [11:0] imm;
    encoding_e   encoding;
  } operation_specification;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // imm[11:6] patterns for OP-IMM shifts
  localparam logic [5:0] IMM_HI_LOGIC = 6'b000000;
  localparam logic [5:0] IMM_HI_ARITH = 6'b010000;

endpackage

// File: rtl/rv64_alu_shifter.sv
// rv64_alu_shifter: combinational 64-bit SLL / SRL / SRA.
module rv64_alu_shifter
  import rv64_alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [5:0]      amount,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  // Left shifts ignore arith; right shifts fill with the sign bit when arith is set.
  always_comb begin
    result = data;
    if (left) begin
      result = data << amount;
    end else if (arith) begin
      result = $unsigned($signed(data) >>> amount);
    end else begin
      result = data >> amount;
    end
  end

endmodule

// File: rtl/rv64_alu.sv
// rv64_alu: single-cycle-registered RV64I integer ALU (OP / OP-IMM).
// Optional feature macro: RV64_ALU_ILLEGAL_CHECK_EN -- when defined, illegal
// encodings clear result_valid; when undefined, no legality check is applied.
//
// Valid semantics: result/result_valid are registered one cycle after the inputs
// are sampled. result_valid is high when the operands were ready (lhs_valid, and
// rhs_valid for R_FORMAT) and the decode was accepted. There is no ready/backpressure;
// one operation is accepted every cycle. result is don't-care when result_valid is 0.
module rv64_alu
  import rv64_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  lhs,
  input  logic [DATA_WIDTH-1:0]  rhs,
  input  logic                   lhs_valid,
  input  logic                   rhs_valid,
  input  operation_specification op_spec,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   result_valid
);

  logic                  is_r;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [5:0]            shamt;
  logic                  alt_f7;
  logic                  imm_hi_arith;
  logic                  do_sub;
  logic                  do_arith_shift;
  logic                  shift_left;
  logic [DATA_WIDTH-1:0] shift_out;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  operands_ready;
  logic                  legal;
  logic                  unused_fields;

  // Register-source fields are tracked by the pipeline, not used for the computation.
  assign unused_fields = ^{op_spec.rs1, op_spec.rs2, op_spec.rd, op_spec.opcode};

  // Operand B / shift amount selection and arithmetic-variant decode.
  // Unrecognised funct7 / imm[11:6] values fall through to the base (non-alt) operation.
  always_comb begin
    is_r           = (op_spec.encoding == R_FORMAT);
    operand_b      = is_r ? rhs : {{(DATA_WIDTH-12){op_spec.imm[11]}}, op_spec.imm};
    shamt          = is_r ? rhs[5:0] : op_spec.imm[5:0];
    alt_f7         = (op_spec.funct7 == F7_ALT);
    imm_hi_arith   = (op_spec.imm[11:6] == IMM_HI_ARITH);
    do_sub         = is_r && alt_f7 && (op_spec.funct3 == F3_ADD);
    do_arith_shift = is_r ? alt_f7 : imm_hi_arith;
    shift_left     = (op_spec.funct3 == F3_SLL);
  end

  rv64_alu_shifter u_shifter (
    .data   (lhs),
    .amount (shamt),
    .left   (shift_left),
    .arith  (do_arith_shift),
    .result (shift_out)
  );

  // Result mux by funct3.
  always_comb begin
    alu_out = '0;
    unique case (op_spec.funct3)
      F3_ADD:  alu_out = do_sub ? (lhs - operand_b) : (lhs + operand_b);
      F3_SLL:  alu_out = shift_out;
      F3_SLT:  alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(lhs) < $signed(operand_b))};
      F3_SLTU: alu_out = {{(DATA_WIDTH-1){1'b0}}, (lhs < operand_b)};
      F3_XOR:  alu_out = lhs ^ operand_b;
      F3_SR:   alu_out = shift_out;
      F3_OR:   alu_out = lhs | operand_b;
      F3_AND:  alu_out = lhs & operand_b;
      default: alu_out = '0;
    endcase
  end

  // Operand readiness and decode legality.
  always_comb begin
    operands_ready = lhs_valid && (!is_r || rhs_valid);
    legal          = 1'b1;
`ifdef RV64_ALU_ILLEGAL_CHECK_EN
    if (is_r) begin
      if (op_spec.opcode != OP) legal = 1'b0;
      if (op_spec.funct7 != F7_BASE && op_spec.funct7 != F7_ALT) legal = 1'b0;
      if (alt_f7 && op_spec.funct3 != F3_ADD && op_spec.funct3 != F3_SR) legal = 1'b0;
    end else begin
      if (op_spec.opcode != OP_IMM) legal = 1'b0;
      if (op_spec.funct3 == F3_SLL && op_spec.imm[11:6] != IMM_HI_LOGIC) legal = 1'b0;
      if (op_spec.funct3 == F3_SR && op_spec.imm[11:6] != IMM_HI_LOGIC && !imm_hi_arith)
        legal = 1'b0;
    end
`endif
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result       <= alu_out;
      result_valid <= operands_ready && legal;
    end
  end

endmodule

// File: tb/tb_rv64_alu.sv
// tb_rv64_alu: directed-vector bench for rv64_alu.
module tb_rv64_alu;
  import rv64_alu_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [63:0]            lhs;
  logic [63:0]            rhs;
  logic                   lhs_valid;
  logic                   rhs_valid;
  operation_specification op_spec;
  logic [63:0]            result;
  logic                   result_valid;

  int compared;
  int mismatched;

  // expected entry: {check_result, valid, result}
  logic [65:0] exp_q[$];

  rv64_alu #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs),
    .rhs          (rhs),
    .lhs_valid    (lhs_valid),
    .rhs_valid    (rhs_valid),
    .op_spec      (op_spec),
    .result       (result),
    .result_valid (result_valid)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one operation at the negedge
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic av,
                       input logic bv, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [11:0] im, input encoding_e enc);
    @(negedge clk);
    lhs              = a;
    rhs              = b;
    lhs_valid        = av;
    rhs_valid        = bv;
    op_spec.opcode   = opc;
    op_spec.rs1      = 5'd1;
    op_spec.funct3   = f3;
    op_spec.rs2      = 5'd2;
    op_spec.rd       = 5'd3;
    op_spec.funct7   = f7;
    op_spec.imm      = im;
    op_spec.encoding = enc;
  endtask

  // scoreboard check one cycle after the drive
  task automatic check(input string tag);
    logic [65:0] e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compared++;
    assert (result_valid === e[64]) else begin
      mismatched++;
      $error("FAIL %s valid observed=%0b expected=%0b", tag, result_valid, e[64]);
    end
    if (e[65]) begin
      compared++;
      assert (result === e[63:0]) else begin
        mismatched++;
        $error("FAIL %s result observed=%h expected=%h", tag, result, e[63:0]);
      end
    end
  endtask

  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic av, input logic bv, input logic [6:0] opc,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] im,
                     input encoding_e enc, input logic [63:0] er, input logic ev);
    drive(a, b, av, bv, opc, f3, f7, im, enc);
    exp_q.push_back({ev, ev, er});
    check(tag);
  endtask

  // hold reset low while a valid ADD is presented; result must be cleared
  task automatic run_reset(input string tag);
    drive(64'd5, 64'd3, 1'b1, 1'b1, OP, F3_ADD, F7_BASE, 12'h0, R_FORMAT);
    rst = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 64'h0});
    check(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    lhs        = '0;
    rhs        = '0;
    lhs_valid  = 1'b0;
    rhs_valid  = 1'b0;
    op_spec    = '0;

    // reset state with a valid op presented
    run_reset("reset_hold");
    run_reset("reset_hold2");
    // release: normal operation on the following cycle
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 64'd8});
    check("reset_release_add");

    // basic R-format
    run("add",   64'd5, 64'd3, 1, 1, OP, F3_ADD, F7_BASE, 12'h0, R_FORMAT, 64'd8, 1);
    run("sub",   64'd5, 64'd3, 1, 1, OP, F3_ADD, F7_ALT,  12'h0, R_FORMAT, 64'd2, 1);
    run("sub_wrap", 64'd0, 64'd1, 1, 1, OP, F3_ADD, F7_ALT, 12'h0, R_FORMAT,
        64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 1, OP, F3_ADD, F7_BASE, 12'h0,
        R_FORMAT, 64'd0, 1);
    run("xor",   64'hF0F0, 64'hFF00, 1, 1, OP, F3_XOR, F7_BASE, 12'h0, R_FORMAT, 64'h0FF0, 1);
    run("or",    64'hF0F0, 64'hFF00, 1, 1, OP, F3_OR,  F7_BASE, 12'h0, R_FORMAT, 64'hFFF0, 1);
    run("and",   64'hF0F0, 64'hFF00, 1, 1, OP, F3_AND, F7_BASE, 12'h0, R_FORMAT, 64'hF000, 1);
    run("sll_mask", 64'd1, 64'd67, 1, 1, OP, F3_SLL, F7_BASE, 12'h0, R_FORMAT, 64'd8, 1);
    run("sra",   64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 1, 1, OP, F3_SR, F7_ALT, 12'h0, R_FORMAT,
        64'hFFFF_FFFF_FFFF_FFFC, 1);
    run("srl",   64'hFFFF_FFFF_FFFF_FFF0, 64'd60, 1, 1, OP, F3_SR, F7_BASE, 12'h0, R_FORMAT,
        64'hF, 1);

    // I-format shifts
    run("srai",  64'h8000_0000_0000_0000, 64'd0, 1, 0, OP_IMM, F3_SR, F7_BASE, 12'h404,
        I_FORMAT, 64'hF800_0000_0000_0000, 1);
    run("srli",  64'h8000_0000_0000_0000, 64'd0, 1, 0, OP_IMM, F3_SR, F7_BASE, 12'h004,
        I_FORMAT, 64'h0800_0000_0000_0000, 1);
    run("slli63", 64'd1, 64'd5, 1, 0, OP_IMM, F3_SLL, F7_BASE, 12'h03F, I_FORMAT,
        64'h8000_0000_0000_0000, 1);

    // compares
    run("slt",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 1, OP, F3_SLT, F7_BASE, 12'h0, R_FORMAT,
        64'd1, 1);
    run("sltu",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 1, OP, F3_SLTU, F7_BASE, 12'h0, R_FORMAT,
        64'd0, 1);
    run("slti_eq", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, OP_IMM, F3_SLT, F7_BASE, 12'hFFF,
        I_FORMAT, 64'd0, 1);
    run("sltiu_sext", 64'd1, 64'd0, 1, 0, OP_IMM, F3_SLTU, F7_BASE, 12'hFFF, I_FORMAT,
        64'd1, 1);

    // immediates and valid gating
    run("addi_neg", 64'd1, 64'd99, 1, 0, OP_IMM, F3_ADD, F7_BASE, 12'hFFF, I_FORMAT, 64'd0, 1);
    run("addi_nosub", 64'd10, 64'd3, 1, 1, OP_IMM, F3_ADD, F7_ALT, 12'h003, I_FORMAT,
        64'd13, 1);
    run("xori_sext", 64'd0, 64'd0, 1, 0, OP_IMM, F3_XOR, F7_BASE, 12'h800, I_FORMAT,
        64'hFFFF_FFFF_FFFF_F800, 1);
    run("r_rhs_notready", 64'd5, 64'd3, 1, 0, OP, F3_ADD, F7_BASE, 12'h0, R_FORMAT, 64'd8, 0);
    run("i_lhs_notready", 64'd5, 64'd3, 0, 1, OP_IMM, F3_ADD, F7_BASE, 12'h1, I_FORMAT,
        64'd6, 0);
    run("r_lhs_notready", 64'd5, 64'd3, 0, 1, OP, F3_ADD, F7_BASE, 12'h0, R_FORMAT, 64'd8, 0);

`ifdef RV64_ALU_ILLEGAL_CHECK_EN
    run("ill_opimm_r", 64'd5, 64'd3, 1, 1, OP_IMM, F3_ADD, F7_BASE, 12'h0, R_FORMAT, 64'd8, 0);
    run("ill_op_i",    64'd5, 64'd3, 1, 1, OP, F3_ADD, F7_BASE, 12'h3, I_FORMAT, 64'd8, 0);
    run("ill_xor_f7",  64'hF0, 64'h0F, 1, 1, OP, F3_XOR, F7_ALT, 12'h0, R_FORMAT, 64'hFF, 0);
    run("ill_f7_01",   64'd5, 64'd3, 1, 1, OP, F3_ADD, 7'h01, 12'h0, R_FORMAT, 64'd8, 0);
    run("ill_srli_hi", 64'h8000_0000_0000_0000, 64'd0, 1, 0, OP_IMM, F3_SR, F7_BASE, 12'h204,
        I_FORMAT, 64'h0800_0000_0000_0000, 0);
    run("ill_slli_arith", 64'd1, 64'd0, 1, 0, OP_IMM, F3_SLL, F7_BASE, 12'h404, I_FORMAT,
        64'd16, 0);
`else
    run("mix_opimm_r", 64'd5, 64'd3, 1, 1, OP_IMM, F3_ADD, F7_BASE, 12'h0, R_FORMAT, 64'd8, 1);
    run("xor_f7alt",   64'hF0, 64'h0F, 1, 1, OP, F3_XOR, F7_ALT, 12'h0, R_FORMAT, 64'hFF, 1);
    run("f7_01_add",   64'd5, 64'd3, 1, 1, OP, F3_ADD, 7'h01, 12'h0, R_FORMAT, 64'd8, 1);
    run("srli_hi_odd", 64'h8000_0000_0000_0000, 64'd0, 1, 0, OP_IMM, F3_SR, F7_BASE, 12'h204,
        I_FORMAT, 64'h0800_0000_0000_0000, 1);
`endif

    // back-to-back op, then reset mid-stream, then recovery
    run("pre_reset_or", 64'h1, 64'h2, 1, 1, OP, F3_OR, F7_BASE, 12'h0, R_FORMAT, 64'h3, 1);
    run_reset("reset_mid");
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 64'd8});
    check("reset_mid_release");
    run("post_reset_sub", 64'd100, 64'd1, 1, 1, OP, F3_ADD, F7_ALT, 12'h0, R_FORMAT, 64'd99, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // safety bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout compared=%0d expected=finish", compared);
    $fatal(1, "timeout");
  end

endmodule
